// File: rtl/msg_printer_multi.sv
// Prints NUL-terminated messages from a slotted ROM when a trigger byte arrives.
// Also echoes stray bytes, queues one follow-up request and aborts on ABORT_CHAR.
module msg_printer_multi #(
  parameter int                   NUM_MSG    = 4,
  parameter int                   SLOT_LEN   = 16,
  parameter int                   ADDR_W     = 6,
  parameter logic [NUM_MSG*8-1:0] TRIG_CHARS = {"d", "c", "b", "a"},
  parameter bit                   ECHO_EN    = 1'b1,
  parameter logic [7:0]           ABORT_CHAR = 8'h1B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              new_rx_data,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              busy,
  output logic [2:0]        msg_id
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_ECHO  = 2'd3;

  localparam int                OFF_W    = $clog2(SLOT_LEN);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(SLOT_LEN - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [2:0]        msg_id_q, msg_id_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              new_tx_q, new_tx_d;
  logic [7:0]        echo_q, echo_d;
  logic              pend_v_q, pend_v_d;
  logic [2:0]        pend_id_q, pend_id_d;

  logic [NUM_MSG-1:0] trig_hit;
  logic [2:0]         trig_idx;
  logic               trig_any;
  logic               abort_hit;
  logic               end_msg;
  logic               abort_now;

  function automatic logic [ADDR_W-1:0] slot_base(input logic [2:0] id);
    slot_base = ADDR_W'(id) << OFF_W;
  endfunction

  for (genvar gi = 0; gi < NUM_MSG; gi++) begin : g_trig
    assign trig_hit[gi] = new_rx_data && (rx_data == TRIG_CHARS[gi*8 +: 8]);
  end

  // Trigger entries are distinct, so at most one hit bit is set and OR-ing indices is exact.
  always_comb begin
    trig_idx = '0;
    for (int i = 0; i < NUM_MSG; i++) begin
      if (trig_hit[i]) trig_idx = trig_idx | 3'(i);
    end
  end

  assign trig_any  = |trig_hit;
  assign abort_hit = new_rx_data && (rx_data == ABORT_CHAR);

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    msg_id_d   = msg_id_q;
    tx_data_d  = tx_data_q;
    new_tx_d   = 1'b0;
    echo_d     = echo_q;
    pend_v_d   = pend_v_q;
    pend_id_d  = pend_id_q;
    end_msg    = 1'b0;
    abort_now  = 1'b0;

    if (state_q != ST_IDLE) begin
      if (abort_hit) begin
        abort_now = 1'b1;
      end else if (trig_any) begin
        pend_v_d  = 1'b1;
        pend_id_d = trig_idx;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (trig_any) begin
          state_d    = ST_FETCH;
          rom_addr_d = slot_base(trig_idx);
          msg_id_d   = trig_idx;
        end else if (new_rx_data && ECHO_EN) begin
          echo_d  = rx_data;
          state_d = ST_ECHO;
        end
      end
      ST_FETCH: state_d = ST_SEND;
      ST_SEND: begin
        if (rom_data == 8'h00) begin
          end_msg = 1'b1;
        end else if (!tx_busy) begin
          new_tx_d  = 1'b1;
          tx_data_d = rom_data;
          if ((rom_addr_q & OFF_MASK) == OFF_MASK) begin
            end_msg = 1'b1;
          end else begin
            // Offset wraps inside the slot; the slot-end test above is what stops the message.
            rom_addr_d = (rom_addr_q & ~OFF_MASK) | ((rom_addr_q + ADDR_W'(1)) & OFF_MASK);
            state_d    = ST_FETCH;
          end
        end
      end
      ST_ECHO: begin
        if (!tx_busy) begin
          new_tx_d  = 1'b1;
          tx_data_d = echo_q;
          end_msg   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_msg) begin
      if (pend_v_d) begin
        state_d    = ST_FETCH;
        rom_addr_d = slot_base(pend_id_d);
        msg_id_d   = pend_id_d;
        pend_v_d   = 1'b0;
      end else begin
        state_d  = ST_IDLE;
        msg_id_d = 3'd0;
      end
    end

    // Abort wins over everything decided above, including a strobe in this cycle.
    if (abort_now) begin
      state_d    = ST_IDLE;
      msg_id_d   = 3'd0;
      pend_v_d   = 1'b0;
      new_tx_d   = 1'b0;
      tx_data_d  = tx_data_q;
      rom_addr_d = rom_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      msg_id_q   <= 3'd0;
      tx_data_q  <= 8'h00;
      new_tx_q   <= 1'b0;
      echo_q     <= 8'h00;
      pend_v_q   <= 1'b0;
      pend_id_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      msg_id_q   <= msg_id_d;
      tx_data_q  <= tx_data_d;
      new_tx_q   <= new_tx_d;
      echo_q     <= echo_d;
      pend_v_q   <= pend_v_d;
      pend_id_q  <= pend_id_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;
  assign rom_addr    = rom_addr_q;
  assign busy        = (state_q != ST_IDLE);
  assign msg_id      = msg_id_q;

endmodule

// File: tb/tb_msg_printer_multi.sv
// Directed and randomized checks of msg_printer_multi against a ROM/transmitter model.
// Expected output is the message text read from the ROM image up to NUL or slot end.
module tb_msg_printer_multi;
  localparam int SLOT_LEN = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       new_rx_data;
  logic [7:0] tx_data, tx_data0;
  logic       new_tx_data, new_tx_data0;
  logic       tx_busy;
  logic [5:0] rom_addr, rom_addr0;
  logic [7:0] rom_data, rom_data0;
  logic       busy, busy0;
  logic [2:0] msg_id, msg_id0;

  logic [7:0] rom [0:63];
  int         busy_cnt;
  int         tx_lat;
  logic       force_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_strobe = -100;
  int max_addr = 0;
  int noecho_strobes = 0;
  logic [7:0] sq[$];
  logic [7:0] expq[$];

  int e_addr [7] = '{16, 16, 17, 17, 18, 18, 18};
  int e_nt   [7] = '{0, 0, 1, 0, 1, 0, 0};
  int e_bz   [7] = '{1, 1, 1, 1, 1, 1, 0};
  int e_id   [7] = '{1, 1, 1, 1, 1, 1, 0};

  always #5 clk = ~clk;

  msg_printer_multi #(.ECHO_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .msg_id(msg_id)
  );

  msg_printer_multi #(.ECHO_EN(1'b0)) dut_noecho (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_data(tx_data0), .new_tx_data(new_tx_data0), .tx_busy(tx_busy),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .busy(busy0), .msg_id(msg_id0)
  );

  // Registered ROM read and a transmitter that stays busy tx_lat cycles per byte.
  always @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    rom_data0 <= rom[rom_addr0];
    if (rst) busy_cnt <= 0;
    else if (new_tx_data) busy_cnt <= tx_lat;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (busy && int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
    if (new_tx_data0) noecho_strobes++;
    if (new_tx_data) begin
      sq.push_back(tx_data);
      chk("strobe_spacing", int'((cyc - last_strobe) >= 2), 1);
      last_strobe = cyc;
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data     = b;
    new_rx_data = 1'b1;
    tick();
    new_rx_data = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < budget);
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic load_str(input int s, input string str);
    for (int k = 0; k < SLOT_LEN; k++)
      rom[s*SLOT_LEN + k] = (k < str.len()) ? str[k] : 8'h00;
  endtask

  task automatic load_rand(input int s, input int len);
    for (int k = 0; k < SLOT_LEN; k++)
      rom[s*SLOT_LEN + k] = (k < len) ? 8'($urandom_range(65, 90)) : 8'h00;
  endtask

  task automatic add_msg(input int s);
    for (int k = 0; k < SLOT_LEN; k++) begin
      if (rom[s*SLOT_LEN + k] == 8'h00) break;
      expq.push_back(rom[s*SLOT_LEN + k]);
    end
  endtask

  task automatic cmp_strobes(input string tag);
    chk({tag, "_count"}, sq.size(), expq.size());
    for (int k = 0; k < sq.size() && k < expq.size(); k++)
      chk(tag, int'(sq[k]), int'(expq[k]));
    sq.delete();
    expq.delete();
  endtask

  function automatic logic [7:0] trig(input int s);
    trig = 8'(8'h61 + s);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_nt"}, int'(new_tx_data), 0);
    chk({tag, "_tx"}, int'(tx_data), 0);
    chk({tag, "_addr"}, int'(rom_addr), 0);
    chk({tag, "_id"}, int'(msg_id), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int s, s2, len, kind;
    logic [7:0] c;
    for (int k = 0; k < 64; k++) rom[k] = 8'h00;
    tx_lat = 0;
    force_busy = 1'b0;
    // Reset with a trigger held on rx: it must be ignored.
    rst = 1'b1;
    rx_data = "a";
    new_rx_data = 1'b1;
    repeat (3) tick();
    chk_reset("reset");
    rst = 1'b0;
    new_rx_data = 1'b0;
    tick();
    chk("reset_rx_ignored", int'(busy), 0);

    // "Hi" in slot 1, cycle by cycle.
    load_str(1, "Hi");
    send_rx("b");
    for (int k = 0; k < 7; k++) begin
      if (k < 6) chk("hi_addr", int'(rom_addr), e_addr[k]);
      chk("hi_nt", int'(new_tx_data), e_nt[k]);
      chk("hi_busy", int'(busy), e_bz[k]);
      chk("hi_id", int'(msg_id), e_id[k]);
      if (k == 2) chk("hi_tx_H", int'(tx_data), int'(8'h48));
      if (k == 4) chk("hi_tx_i", int'(tx_data), int'(8'h69));
      if (k < 6) tick();
    end
    add_msg(1);
    cmp_strobes("hi_bytes");
    $display("txn directed hi done");

    // Echo while the transmitter is busy; the no-echo instance drops it.
    noecho_strobes = 0;
    force_busy = 1'b1;
    send_rx("z");
    chk("noecho_busy", int'(busy0), 0);
    repeat (4) tick();
    chk("echo_hold_busy", int'(busy), 1);
    chk("echo_hold_nostrobe", sq.size(), 0);
    force_busy = 1'b0;
    tick();
    chk("echo_nt", int'(new_tx_data), 1);
    chk("echo_tx", int'(tx_data), int'(8'h7A));
    tick();
    chk("echo_idle", int'(busy), 0);
    chk("noecho_strobes", noecho_strobes, 0);
    sq.delete();
    $display("txn directed echo done");

    // Full 16-byte slot: stops at the slot end without leaving slot 0.
    load_rand(0, 16);
    tx_lat = 1;
    max_addr = 0;
    send_rx("a");
    wait_idle(300);
    add_msg(0);
    cmp_strobes("full_slot");
    chk("full_max_addr", max_addr, 15);
    $display("txn directed full slot done");

    // Pending request: later trigger overwrites earlier one, chained without an idle gap.
    load_str(0, "ABCDEF");
    load_str(2, "QQ");
    load_str(3, "XYZ");
    tx_lat = 2;
    send_rx("a");
    repeat (2) tick();
    send_rx("c");
    send_rx("d");
    wait_idle(400);
    add_msg(0);
    add_msg(3);
    cmp_strobes("pending");
    $display("txn directed pending done");

    // Abort lands in the cycle SEND would strobe; pending "c" must be dropped too.
    tx_lat = 0;
    send_rx("a");
    send_rx("c");
    send_rx(8'h1B);
    chk("abort_nt", int'(new_tx_data), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_id", int'(msg_id), 0);
    repeat (6) tick();
    chk("abort_stays_idle", int'(busy), 0);
    chk("abort_no_strobes", sq.size(), 0);
    $display("txn directed abort done");

    // Reset in the middle of a message with a request pending.
    load_rand(1, 16);
    tx_lat = 1;
    send_rx("b");
    repeat (5) tick();
    send_rx("c");
    rst = 1'b1;
    rx_data = "a";
    new_rx_data = 1'b1;
    tick();
    chk_reset("midrst");
    tick();
    rst = 1'b0;
    new_rx_data = 1'b0;
    tick();
    chk("midrst_idle", int'(busy), 0);
    sq.delete();
    send_rx("a");
    chk("midrst_addr", int'(rom_addr), 0);
    chk("midrst_id", int'(msg_id), 0);
    chk("midrst_busy", int'(busy), 1);
    wait_idle(300);
    add_msg(0);
    cmp_strobes("midrst_msg");
    $display("txn directed midreset done");

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      s = $urandom_range(0, 3);
      s2 = $urandom_range(0, 3);
      len = $urandom_range(0, 16);
      kind = $urandom_range(0, 2);
      tx_lat = $urandom_range(0, 3);
      load_rand(s, len);
      if (s2 != s) load_rand(s2, $urandom_range(0, 16));
      if (kind == 2) begin
        c = 8'($urandom_range(101, 122));
        send_rx(c);
        wait_idle(60);
        expq.push_back(c);
      end else begin
        send_rx(trig(s));
        chk("rnd_id", int'(msg_id), s);
        add_msg(s);
        if (kind == 1) begin
          repeat ($urandom_range(0, 3)) tick();
          send_rx(trig(s2));
          add_msg(s2);
        end
        wait_idle(600);
      end
      $display("txn %0d kind %0d slot %0d/%0d lat %0d strobes %0d expected %0d",
               t, kind, s, s2, tx_lat, sq.size(), expq.size());
      cmp_strobes("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
